// File: rtl/pred_box_loader.sv
// rtl/pred_box_loader.sv - packs AXIS prediction beats into box words for the NMS controller.
// Optional build macro LOADER_SCORE_FILTER_EN drops boxes whose score is below score_thresh.
module pred_box_loader #(
    parameter int DATA_W        = 32,
    parameter int WORDS_PER_BOX = 3,
    parameter int BOX_W         = DATA_W * WORDS_PER_BOX,
    parameter int ADDR_W        = 10,
    parameter int MAX_PRED      = 1024,
    parameter int SCORE_MSB     = 95
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              pmem_wren,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [BOX_W-1:0]  pmem_wdata,
    output logic [ADDR_W:0]   num_pred,
    output logic              start,
    input  logic              done_int,
    output logic              busy,
    output logic              err_partial,
    output logic              err_overflow,
    input  logic [15:0]       score_thresh
);

    localparam int CNT_W = (WORDS_PER_BOX > 1) ? $clog2(WORDS_PER_BOX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_BOX - 1);
    localparam logic [ADDR_W:0]  MAX_CNT   = (ADDR_W + 1)'(MAX_PRED);

    localparam logic [1:0] ST_RECV       = 2'd0;
    localparam logic [1:0] ST_COMMIT     = 2'd1;
    localparam logic [1:0] ST_START_HOLD = 2'd2;
    localparam logic [1:0] ST_RELEASE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [BOX_W-1:0]  shift_q, shift_d;
    logic              tready_q, tready_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BOX_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W:0]   num_pred_q, num_pred_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              err_partial_q, err_partial_d;
    logic              err_overflow_q, err_overflow_d;

    logic              hs;
    logic              first_beat;
    logic [BOX_W-1:0]  box_nxt;
    logic              box_keep;
    logic [ADDR_W:0]   np_base;

    assign hs         = s_axis_tvalid && tready_q && (state_q == ST_RECV);
    assign first_beat = !busy_q;
    assign np_base    = first_beat ? '0 : num_pred_q;

    always_comb begin
        box_nxt = shift_q;
        box_nxt[int'(beat_cnt_q) * DATA_W +: DATA_W] = s_axis_tdata;
    end

`ifdef LOADER_SCORE_FILTER_EN
    assign box_keep = (box_nxt[SCORE_MSB -: 16] >= score_thresh);
`else
    logic unused_score_thresh;
    assign unused_score_thresh = ^score_thresh;
    assign box_keep = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        shift_d        = shift_q;
        wren_d         = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        num_pred_d     = num_pred_q;
        busy_d         = busy_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;

        case (state_q)
            ST_RECV: begin
                if (hs) begin
                    busy_d     = 1'b1;
                    shift_d    = box_nxt;
                    num_pred_d = np_base;
                    if (first_beat) begin
                        err_partial_d  = 1'b0;
                        err_overflow_d = 1'b0;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        if (box_keep) begin
                            if (np_base == MAX_CNT) begin
                                err_overflow_d = 1'b1;
                            end else begin
                                wren_d     = 1'b1;
                                addr_d     = np_base[ADDR_W-1:0];
                                wdata_d    = box_nxt;
                                num_pred_d = np_base + 1'b1;
                            end
                        end
                    end else if (s_axis_tlast) begin
                        // Frame ended mid-box: the collected beats are dropped.
                        beat_cnt_d    = '0;
                        err_partial_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (s_axis_tlast) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_START_HOLD;
            end
            ST_START_HOLD: begin
                if (done_int) begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                if (!done_int) begin
                    state_d    = ST_RECV;
                    beat_cnt_d = '0;
                    busy_d     = 1'b0;
                end
            end
        endcase

        tready_d = (state_d == ST_RECV);
        start_d  = (state_d == ST_START_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_RECV;
            beat_cnt_q     <= '0;
            shift_q        <= '0;
            tready_q       <= 1'b0;
            wren_q         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            num_pred_q     <= '0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            shift_q        <= shift_d;
            tready_q       <= tready_d;
            wren_q         <= wren_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            num_pred_q     <= num_pred_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign pmem_wren     = wren_q;
    assign pmem_addr     = addr_q;
    assign pmem_wdata    = wdata_q;
    assign num_pred      = num_pred_q;
    // Reset must pull start down in the same cycle, not one edge later.
    assign start         = start_q && resetn;
    assign busy          = busy_q;
    assign err_partial   = err_partial_q;
    assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_pred_box_loader.sv
// tb/tb_pred_box_loader.sv - self-checking bench for pred_box_loader (table vectors, random frames, reset cases).
module tb_pred_box_loader;

    localparam int DW   = 32;
    localparam int WPB  = 3;
    localparam int BW   = DW * WPB;
    localparam int AW   = 10;
    localparam int MAXP = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          pmem_wren;
    logic [AW-1:0] pmem_addr;
    logic [BW-1:0] pmem_wdata;
    logic [AW:0]   num_pred;
    logic          start;
    logic          done_int = 1'b0;
    logic          busy;
    logic          err_partial;
    logic          err_overflow;
    logic [15:0]   score_thresh = 16'h4000;

    pred_box_loader #(.DATA_W(DW), .WORDS_PER_BOX(WPB), .ADDR_W(AW), .MAX_PRED(MAXP)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .pmem_wren(pmem_wren), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .num_pred(num_pred), .start(start), .done_int(done_int), .busy(busy),
        .err_partial(err_partial), .err_overflow(err_overflow),
        .score_thresh(score_thresh)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nbeats;
        int gap;
        int done_cyc;
        int exp_np;
        bit exp_part;
        bit exp_ovf;
    } vec_t;

    vec_t          vecs[8];
    int            pass_cnt = 0;
    int            tot_cnt = 0;
    logic [DW-1:0] frame_data[64];
    logic [BW-1:0] wq_data[$];
    int            wq_addr[$];
    logic [BW-1:0] ex_data[$];
    int            ex_addr[$];

    always @(negedge clk) begin
        if (pmem_wren) begin
            wq_data.push_back(pmem_wdata);
            wq_addr.push_back(int'(pmem_addr));
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] pack(input int k);
        return {frame_data[3*k+2], frame_data[3*k+1], frame_data[3*k]};
    endfunction

    function automatic bit keep(input logic [BW-1:0] b);
`ifdef LOADER_SCORE_FILTER_EN
        return b[95:80] >= score_thresh;
`else
        return (b == b);
`endif
    endfunction

    task automatic fill_data(input int n, input bit force_score);
        for (int i = 0; i < n; i++) begin
            frame_data[i] = $urandom;
            if (force_score && (i % WPB == WPB - 1)) frame_data[i][31:16] = 16'hFFFF;
        end
    endtask

    // Reference: whole boxes = n / WPB; a remainder means a partial tail; stores stop at MAXP.
    task automatic model(input int n, output int np, output bit part, output bit ovf);
        logic [BW-1:0] b;
        np = 0;
        ovf = 1'b0;
        part = (n % WPB) != 0;
        ex_data.delete();
        ex_addr.delete();
        for (int k = 0; k < n / WPB; k++) begin
            b = pack(k);
            if (keep(b)) begin
                if (np < MAXP) begin
                    ex_data.push_back(b);
                    ex_addr.push_back(np);
                    np++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input string tag, input int n, input int gap, input int done_cyc,
                             input int e_np, input bit e_part, input bit e_ovf);
        int got = 0;
        int stored = 0;
        int cyc = 0;
        int mnp;
        bit mpart, movf;
        bit prev_hs = 1'b0;
        bit v;
        logic [BW-1:0] b;
        model(n, mnp, mpart, movf);
        wq_data.delete();
        wq_addr.delete();
        forever begin
            @(negedge clk);
            if (prev_hs && (got % WPB == 0)) begin
                b = pack(got / WPB - 1);
                if (keep(b) && stored < MAXP) begin
                    chk({tag, " wren"}, pmem_wren, 1);
                    chk({tag, " addr"}, pmem_addr, stored);
                    stored++;
                end else begin
                    chk({tag, " no_wren"}, pmem_wren, 0);
                end
            end
            if (prev_hs && got == 1 && n > 1) begin
                chk({tag, " busy_first"}, busy, 1);
                chk({tag, " clr_partial"}, err_partial, 0);
                chk({tag, " clr_overflow"}, err_overflow, 0);
                chk({tag, " clr_num_pred"}, num_pred, 0);
            end
            if (got == n || cyc > 2000) break;
            cyc++;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            s_axis_tvalid = v;
            s_axis_tdata  = v ? frame_data[got] : DW'($urandom);
            s_axis_tlast  = v && (got == n - 1);
            done_int      = (gap == 2) ? 1'($urandom % 2) : 1'b0;
            prev_hs = v && s_axis_tready;
            if (prev_hs) got++;
        end
        chk({tag, " handshakes"}, got, n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        done_int      = 1'b0;
        chk({tag, " commit_tready"}, s_axis_tready, 0);
        chk({tag, " commit_start"}, start, 0);
        @(negedge clk);
        chk({tag, " start"}, start, 1);
        chk({tag, " hold_tready"}, s_axis_tready, 0);
        chk({tag, " num_pred"}, num_pred, e_np);
        chk({tag, " num_pred_model"}, num_pred, mnp);
        chk({tag, " err_partial"}, err_partial, e_part);
        chk({tag, " err_overflow"}, err_overflow, e_ovf);
        chk({tag, " err_model"}, {err_partial, err_overflow}, {mpart, movf});
        chk({tag, " busy"}, busy, 1);
        chk({tag, " write_count"}, wq_data.size(), ex_data.size());
        for (int i = 0; i < ex_data.size() && i < wq_data.size(); i++) begin
            chk({tag, " wdata"}, wq_data[i], ex_data[i]);
            chk({tag, " waddr"}, wq_addr[i], ex_addr[i]);
        end
        for (int j = 0; j < done_cyc; j++) begin
            done_int = 1'b1;
            @(negedge clk);
            chk({tag, " release_start"}, start, 0);
            chk({tag, " release_tready"}, s_axis_tready, 0);
            chk({tag, " release_np"}, num_pred, e_np);
        end
        done_int = 1'b0;
        @(negedge clk);
        chk({tag, " recv_tready"}, s_axis_tready, 1);
        chk({tag, " idle_busy"}, busy, 0);
        chk({tag, " held_np"}, num_pred, e_np);
        chk({tag, " held_partial"}, err_partial, e_part);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int np;
        bit pt, ov;
        int n;
        vecs[0] = '{6,  0, 3, 2, 1'b0, 1'b0};
        vecs[1] = '{6,  1, 4, 2, 1'b0, 1'b0};
        vecs[2] = '{4,  0, 1, 1, 1'b1, 1'b0};
        vecs[3] = '{15, 0, 2, 4, 1'b0, 1'b1};
        vecs[4] = '{3,  1, 1, 1, 1'b0, 1'b0};
        vecs[5] = '{2,  0, 2, 0, 1'b1, 1'b0};
        vecs[6] = '{14, 2, 1, 4, 1'b1, 1'b0};
        vecs[7] = '{16, 1, 3, 4, 1'b1, 1'b1};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tready", s_axis_tready, 0);
        chk("rst outputs", {pmem_wren, start, busy, err_partial, err_overflow}, 0);
        chk("rst num_pred", num_pred, 0);
        chk("rst addr_data", {pmem_addr, pmem_wdata}, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst tready", s_axis_tready, 1);

        for (int i = 0; i < 8; i++) begin
            fill_data(vecs[i].nbeats, 1'b1);
            run_frame($sformatf("vec%0d", i), vecs[i].nbeats, vecs[i].gap, vecs[i].done_cyc,
                      vecs[i].exp_np, vecs[i].exp_part, vecs[i].exp_ovf);
        end

        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(1, 16);
            fill_data(n, 1'b0);
            model(n, np, pt, ov);
            run_frame($sformatf("rnd%0d", r), n, $urandom_range(0, 2), $urandom_range(1, 4), np, pt, ov);
        end

        // Reset during the second beat of the second box.
        fill_data(6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = frame_data[i];
            @(negedge clk);
        end
        resetn = 1'b0;
        s_axis_tdata = frame_data[4];
        @(negedge clk);
        chk("midrst tready", s_axis_tready, 0);
        chk("midrst num_pred", num_pred, 0);
        chk("midrst start_busy", {start, busy}, 0);
        resetn = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        fill_data(3, 1'b1);
        run_frame("post_midrst", 3, 0, 1, 1, 1'b0, 1'b0);

        // Reset while start is held.
        fill_data(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = frame_data[i];
            s_axis_tlast  = (i == 2);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk);
        chk("holdrst start_before", start, 1);
        resetn = 1'b0;
        #1;
        chk("holdrst start_immediate", start, 0);
        @(negedge clk);
        chk("holdrst state", {start, s_axis_tready, busy}, 0);
        chk("holdrst num_pred", num_pred, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("holdrst tready", s_axis_tready, 1);

`ifdef LOADER_SCORE_FILTER_EN
        fill_data(9, 1'b0);
        frame_data[2][31:16] = 16'h3FFF;
        frame_data[5][31:16] = 16'h4000;
        frame_data[8][31:16] = 16'h8000;
        run_frame("filter", 9, 0, 1, 2, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
